// File: rtl/tdm_pkg.sv
// tdm_pkg: slot geometry and framer state encoding shared by TDM mux/demux ends
package tdm_pkg;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W = 3;
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;
endpackage

// File: rtl/tdm_demux1x8_if.sv
// tdm_demux1x8_if: serial slot input and reassembled-frame output bundle
interface tdm_demux1x8_if #(parameter int DATA_W = 1);
    import tdm_pkg::*;
    logic [DATA_W-1:0] din;
    logic din_valid;
    logic frame_sync;
    logic [NUM_SLOTS*DATA_W-1:0] y;
    logic frame_valid;
    logic [SLOT_W-1:0] slot;
    logic locked;
    logic sync_err;
    modport master(output din, din_valid, frame_sync, input y, frame_valid, slot, locked, sync_err);
    modport slave(input din, din_valid, frame_sync, output y, frame_valid, slot, locked, sync_err);
endinterface

// File: rtl/tdm_slot_cnt.sv
// tdm_slot_cnt: wrapping slot index counter; clr beats load1 beats en
module tdm_slot_cnt import tdm_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load1,
    input  logic clr,
    output logic [SLOT_W-1:0] slot
);
    logic [SLOT_W-1:0] cnt_d, cnt_q;
    always_comb cnt_d = clr ? '0 : load1 ? SLOT_W'(1) : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign slot = cnt_q;
endmodule

// File: rtl/tdm_demux1x8.sv
// tdm_demux1x8: 8-slot TDM receive framer; define TDM_DEMUX_SYNC_CHECK_EN to police frame_sync while locked
module tdm_demux1x8 import tdm_pkg::*; #(parameter int DATA_W = 1) (
    input logic clk,
    input logic rst,
    tdm_demux1x8_if.slave bus
);
    state_e state_d, state_q;
    logic [(NUM_SLOTS-1)*DATA_W-1:0] shadow_d, shadow_q;
    logic [NUM_SLOTS*DATA_W-1:0] y_d, y_q;
    logic fv_d, fv_q, err_d, err_q;
    logic cnt_en, cnt_ld, cnt_clr, abort, lose;
    logic [SLOT_W-1:0] slot;

    tdm_slot_cnt u_cnt (.clk(clk), .rst(rst), .en(cnt_en), .load1(cnt_ld), .clr(cnt_clr), .slot(slot));

    // abort: early sync restarts the frame; lose: missing sync drops lock
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    assign abort = bus.frame_sync && slot != '0;
    assign lose = !bus.frame_sync && slot == '0;
`else
    assign abort = 1'b0;
    assign lose = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shadow_d = shadow_q;
        y_d = y_q;
        fv_d = 1'b0;
        err_d = 1'b0;
        cnt_en = 1'b0;
        cnt_ld = 1'b0;
        cnt_clr = 1'b0;
        if (bus.din_valid) begin
            if (state_q == HUNT) begin
                if (bus.frame_sync) begin
                    shadow_d[DATA_W-1:0] = bus.din;
                    cnt_ld = 1'b1;
                    state_d = LOCKED;
                end
            end else if (abort) begin
                err_d = 1'b1;
                shadow_d[DATA_W-1:0] = bus.din;
                cnt_ld = 1'b1;
            end else if (lose) begin
                err_d = 1'b1;
                cnt_clr = 1'b1;
                state_d = HUNT;
            end else begin
                cnt_en = 1'b1;
                if (slot == SLOT_W'(NUM_SLOTS-1)) begin
                    y_d = {bus.din, shadow_q};
                    fv_d = 1'b1;
                end
                for (int k = 0; k < NUM_SLOTS-1; k++)
                    if (slot == SLOT_W'(k)) shadow_d[k*DATA_W +: DATA_W] = bus.din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            shadow_q <= '0;
            y_q <= '0;
            fv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shadow_q <= shadow_d;
            y_q <= y_d;
            fv_q <= fv_d;
            err_q <= err_d;
        end
    end

    assign bus.y = y_q;
    assign bus.frame_valid = fv_q;
    assign bus.slot = slot;
    assign bus.locked = state_q == LOCKED;
    assign bus.sync_err = err_q;
endmodule

// File: tb/tb_tdm_demux1x8.sv
// tb_tdm_demux1x8: directed checks of framing, stalls, back-to-back frames, reset and sync handling
module tb_tdm_demux1x8;
    logic clk, rst;
    int n_cmp, n_err;
    tdm_demux1x8_if #(.DATA_W(1)) bus();
    tdm_demux1x8 #(.DATA_W(1)) dut(.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change on the falling edge, outputs are sampled on the next falling edge
    task automatic step(input logic v, input logic s, input logic d, input logic r = 1'b0);
        bus.din_valid = v;
        bus.frame_sync = s;
        bus.din = d;
        rst = r;
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_cmp++; if (bus.y !== 8'h00) begin n_err++; $display("FAIL reset_y got %0h want 00", bus.y); end
        n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv got %0b want 0", bus.frame_valid); end
        n_cmp++; if (bus.slot !== 3'd0) begin n_err++; $display("FAIL reset_slot got %0d want 0", bus.slot); end
        n_cmp++; if (bus.locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %0b want 0", bus.locked); end
        n_cmp++; if (bus.sync_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b want 0", bus.sync_err); end
    endtask

    task automatic test_basic;
        logic [7:0] f = 8'h4D;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, k == 0, f[k]);
            n_cmp++; if (bus.frame_valid !== (k == 7)) begin n_err++; $display("FAIL basic_fv slot %0d got %0b want %0b", k, bus.frame_valid, k == 7); end
            n_cmp++; if (bus.slot !== 3'(k + 1)) begin n_err++; $display("FAIL basic_slot beat %0d got %0d want %0d", k, bus.slot, 3'(k + 1)); end
            n_cmp++; if (bus.locked !== 1'b1) begin n_err++; $display("FAIL basic_locked beat %0d got %0b want 1", k, bus.locked); end
        end
        n_cmp++; if (bus.y !== 8'h4D) begin n_err++; $display("FAIL basic_y got %0h want 4d", bus.y); end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL basic_fv_drop got %0b want 0", bus.frame_valid); end
        n_cmp++; if (bus.y !== 8'h4D) begin n_err++; $display("FAIL basic_y_hold got %0h want 4d", bus.y); end
    endtask

    task automatic test_stall;
        logic [7:0] f = 8'h4D;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, k == 0, f[k]);
            n_cmp++; if (bus.frame_valid !== (k == 7)) begin n_err++; $display("FAIL stall_fv slot %0d got %0b want %0b", k, bus.frame_valid, k == 7); end
            if (k == 3)
                for (int i = 0; i < 3; i++) begin
                    step(1'b0, 1'b1, 1'b1);
                    n_cmp++; if (bus.slot !== 3'd4) begin n_err++; $display("FAIL stall_slot idle %0d got %0d want 4", i, bus.slot); end
                    n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL stall_fv idle %0d got %0b want 0", i, bus.frame_valid); end
                end
        end
        n_cmp++; if (bus.y !== 8'h4D) begin n_err++; $display("FAIL stall_y got %0h want 4d", bus.y); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] fr [2] = '{8'hA5, 8'h3C};
        logic [7:0] prev = 8'h4D;
        logic [7:0] f;
        for (int j = 0; j < 2; j++) begin
            f = fr[j];
            for (int k = 0; k < 8; k++) begin
                step(1'b1, k == 0, f[k]);
                n_cmp++; if (bus.frame_valid !== (k == 7)) begin n_err++; $display("FAIL b2b_fv frame %0d slot %0d got %0b want %0b", j, k, bus.frame_valid, k == 7); end
                n_cmp++; if (bus.y !== (k == 7 ? f : prev)) begin n_err++; $display("FAIL b2b_y frame %0d slot %0d got %0h want %0h", j, k, bus.y, k == 7 ? f : prev); end
            end
            prev = f;
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 3; k++) step(1'b1, k == 0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        test_reset;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 1'b1);
            n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL nosync_fv beat %0d got %0b want 0", k, bus.frame_valid); end
            n_cmp++; if (bus.locked !== 1'b0 || bus.slot !== 3'd0) begin n_err++; $display("FAIL nosync_hunt beat %0d got locked %0b slot %0d want 0 0", k, bus.locked, bus.slot); end
        end
        n_cmp++; if (bus.y !== 8'h00) begin n_err++; $display("FAIL nosync_y got %0h want 00", bus.y); end
    endtask

    task automatic test_sync;
        logic [7:0] f = 8'hB3;
        logic [7:0] g = 8'h55;
        for (int k = 0; k < 8; k++) step(1'b1, k == 0, 1'b0);
        n_cmp++; if (bus.y !== 8'h00 || bus.frame_valid !== 1'b1) begin n_err++; $display("FAIL sync_lock got y %0h fv %0b want 00 1", bus.y, bus.frame_valid); end
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, f[k]);
        step(1'b1, 1'b1, f[5]);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        n_cmp++; if (bus.sync_err !== 1'b1) begin n_err++; $display("FAIL early_err got %0b want 1", bus.sync_err); end
        n_cmp++; if (bus.slot !== 3'd1) begin n_err++; $display("FAIL early_slot got %0d want 1", bus.slot); end
        n_cmp++; if (bus.y !== 8'h00 || bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL early_y got %0h fv %0b want 00 0", bus.y, bus.frame_valid); end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.sync_err !== 1'b0) begin n_err++; $display("FAIL early_err_drop got %0b want 0", bus.sync_err); end
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, g[k]);
        n_cmp++; if (bus.y !== 8'h55 || bus.frame_valid !== 1'b1) begin n_err++; $display("FAIL realign_y got %0h fv %0b want 55 1", bus.y, bus.frame_valid); end
        step(1'b1, 1'b0, 1'b1);
        n_cmp++; if (bus.sync_err !== 1'b1) begin n_err++; $display("FAIL miss_err got %0b want 1", bus.sync_err); end
        n_cmp++; if (bus.locked !== 1'b0 || bus.slot !== 3'd0) begin n_err++; $display("FAIL miss_hunt got locked %0b slot %0d want 0 0", bus.locked, bus.slot); end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.sync_err !== 1'b0 || bus.y !== 8'h55) begin n_err++; $display("FAIL miss_after got err %0b y %0h want 0 55", bus.sync_err, bus.y); end
`else
        n_cmp++; if (bus.sync_err !== 1'b0) begin n_err++; $display("FAIL early_err got %0b want 0", bus.sync_err); end
        n_cmp++; if (bus.slot !== 3'd6) begin n_err++; $display("FAIL early_slot got %0d want 6", bus.slot); end
        for (int k = 6; k < 8; k++) step(1'b1, 1'b0, f[k]);
        n_cmp++; if (bus.y !== 8'hB3 || bus.frame_valid !== 1'b1) begin n_err++; $display("FAIL freerun_y got %0h fv %0b want b3 1", bus.y, bus.frame_valid); end
        step(1'b1, 1'b0, 1'b1);
        n_cmp++; if (bus.sync_err !== 1'b0) begin n_err++; $display("FAIL miss_err got %0b want 0", bus.sync_err); end
        n_cmp++; if (bus.locked !== 1'b1 || bus.slot !== 3'd1) begin n_err++; $display("FAIL miss_locked got locked %0b slot %0d want 1 1", bus.locked, bus.slot); end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.frame_sync = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_basic;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        test_sync;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
